// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared pipeline types and hazard sequencer state encoding
package pipeline_hazard_controller_pkg;
  localparam int PC_W  = 32;
  localparam int REG_W = 5;
  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [REG_W-1:0] reg_addr_t;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} hazard_state_e;
endpackage

// File: rtl/pipeline_hazard_controller_mispredict_detector.sv
// mispredict_detector: resolves the correct next PC of the MA instruction and flags a wrong fetch
module mispredict_detector #(
  parameter int PC_WIDTH = 32
) (
  input  logic                ma_valid,
  input  logic                ma_is_branch,
  input  logic                ma_branch_taken,
  input  logic [PC_WIDTH-1:0] ma_predicted_next_pc,
  input  logic [PC_WIDTH-1:0] ma_irreg_pc,
  input  logic [PC_WIDTH-1:0] ma_pc,
  output logic [PC_WIDTH-1:0] actual,
  output logic                mispredict
);
  logic [PC_WIDTH-1:0] fallthrough;
  // Comparing the resolved PC against the fetched one catches direction, target and missing-target errors alike
  always_comb begin
    fallthrough = ma_pc + PC_WIDTH'(4);
    actual      = ma_branch_taken ? ma_irreg_pc : fallthrough;
    mispredict  = ma_valid & ma_is_branch & (actual != ma_predicted_next_pc);
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer with PC redirect and misprediction counter
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int PC_WIDTH       = PC_W,
  parameter int REG_ADDR_WIDTH = REG_W,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ma_valid,
  input  logic                      ma_is_branch,
  input  logic                      ma_branch_taken,
  input  logic                      ma_taken_predicted,
  input  logic                      ma_next_pc_predicted,
  input  logic [PC_WIDTH-1:0]       ma_predicted_next_pc,
  input  logic [PC_WIDTH-1:0]       ma_irreg_pc,
  input  logic [PC_WIDTH-1:0]       ma_pc,
  input  logic                      ma_dmem_req,
  input  logic                      dmem_ack,
  input  logic                      ex_rd_wen,
  input  logic                      ex_rd_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      stall_ma,
  output logic                      flush_id,
  output logic                      flush_ex,
  output logic                      flush_wb,
  output logic                      redirect_valid,
  output logic [PC_WIDTH-1:0]       redirect_pc,
  output logic [CNT_WIDTH-1:0]      mispredict_count
);
  hazard_state_e       state_q, state_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] actual;
  logic                mispredict, mem_wait, load_use;
  logic                hold, redir, lu_ok;
  // The predicted-PC compare already encodes direction and BTB hit, so these flags are redundant here
  logic                unused_pred_flags;
  assign unused_pred_flags = ma_taken_predicted ^ ma_next_pc_predicted;

  mispredict_detector #(.PC_WIDTH(PC_WIDTH)) u_det (
    .ma_valid             (ma_valid),
    .ma_is_branch         (ma_is_branch),
    .ma_branch_taken      (ma_branch_taken),
    .ma_predicted_next_pc (ma_predicted_next_pc),
    .ma_irreg_pc          (ma_irreg_pc),
    .ma_pc                (ma_pc),
    .actual               (actual),
    .mispredict           (mispredict)
  );

  // Raw hazard conditions before state-based qualification
  always_comb begin
    mem_wait = ma_valid & ma_dmem_req & ~dmem_ack;
    load_use = ex_rd_wen & ex_rd_is_load & (ex_rd_addr != '0) &
               ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) | (id_rs2_used & (id_rs2_addr == ex_rd_addr)));
  end

  // State, redirect and counter registers; reset drops any pending redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      cnt_q            <= cnt_d;
    end
  end

  // Next state: memory wait beats a redirect; FLUSH lasts exactly one cycle
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    cnt_d            = cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) state_d = MEM_WAIT;
        else if (mispredict) begin
          state_d          = FLUSH;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = actual;
          cnt_d            = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
        end
      end
      MEM_WAIT: state_d = dmem_ack ? RUN : MEM_WAIT;
      FLUSH:    state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Stage controls; load-use only fires when nothing of higher priority is active, and all are quiet in reset
  always_comb begin
    hold     = rst & (((state_q == RUN) & mem_wait) | ((state_q == MEM_WAIT) & ~dmem_ack));
    redir    = rst & (state_q == RUN) & ~mem_wait & mispredict;
    lu_ok    = rst & load_use & (((state_q == RUN) & ~mem_wait & ~mispredict) | ((state_q == MEM_WAIT) & dmem_ack));
    stall_if = hold | lu_ok;
    stall_id = hold | lu_ok;
    stall_ex = hold;
    stall_ma = hold;
    flush_wb = hold;
    flush_id = redir | (rst & (state_q == FLUSH));
    flush_ex = redir | lu_ok;
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: vector table, corner sequences and random stimulus against a reference model
module tb_pipeline_hazard_controller;
  logic clk = 1'b0, rst = 1'b0;
  logic ma_valid, ma_is_branch, ma_branch_taken, ma_taken_predicted, ma_next_pc_predicted;
  logic [31:0] ma_predicted_next_pc, ma_irreg_pc, ma_pc;
  logic ma_dmem_req, dmem_ack, ex_rd_wen, ex_rd_is_load, id_rs1_used, id_rs2_used;
  logic [4:0] ex_rd_addr, id_rs1_addr, id_rs2_addr;
  logic stall_if, stall_id, stall_ex, stall_ma, flush_id, flush_ex, flush_wb, redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0] mispredict_count;
  int errors = 0, checks = 0;
  bit m_wait = 0, m_flush = 0;
  logic [31:0] m_rpc = 0;
  int m_cnt = 0;
  logic [6:0] last_ctrl;

  typedef struct {
    logic v, b, t, pt, npp;
    logic [31:0] pred, irreg, pc;
    logic req, ack, wen, ld;
    logic [4:0] rd;
    logic u1, u2;
    logic [4:0] r1, r2;
    logic [6:0] exp_ctrl;
    logic exp_rv;
    logic [31:0] exp_rpc;
  } vec_t;
  vec_t tbl[10];

  pipeline_hazard_controller #(.PC_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ma_valid(ma_valid), .ma_is_branch(ma_is_branch),
    .ma_branch_taken(ma_branch_taken), .ma_taken_predicted(ma_taken_predicted),
    .ma_next_pc_predicted(ma_next_pc_predicted), .ma_predicted_next_pc(ma_predicted_next_pc),
    .ma_irreg_pc(ma_irreg_pc), .ma_pc(ma_pc), .ma_dmem_req(ma_dmem_req), .dmem_ack(dmem_ack),
    .ex_rd_wen(ex_rd_wen), .ex_rd_is_load(ex_rd_is_load), .ex_rd_addr(ex_rd_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_ma(stall_ma), .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl();
    return {stall_if, stall_id, stall_ex, stall_ma, flush_id, flush_ex, flush_wb};
  endfunction

  function automatic vec_t br(logic [31:0] pc, logic [31:0] pred, logic [31:0] irreg, logic t, logic pt,
                              logic npp, logic [6:0] e, logic rv, logic [31:0] rpc);
    vec_t x = '{default: '0};
    x.v = 1; x.b = 1; x.pc = pc; x.pred = pred; x.irreg = irreg; x.t = t; x.pt = pt; x.npp = npp;
    x.exp_ctrl = e; x.exp_rv = rv; x.exp_rpc = rpc;
    return x;
  endfunction

  function automatic vec_t lu(logic wen, logic ld, logic [4:0] rd, logic u1, logic u2, logic [4:0] r1,
                              logic [4:0] r2, logic [6:0] e);
    vec_t x = '{default: '0};
    x.wen = wen; x.ld = ld; x.rd = rd; x.u1 = u1; x.u2 = u2; x.r1 = r1; x.r2 = r2; x.exp_ctrl = e;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t x);
    ma_valid = x.v; ma_is_branch = x.b; ma_branch_taken = x.t; ma_taken_predicted = x.pt;
    ma_next_pc_predicted = x.npp; ma_predicted_next_pc = x.pred; ma_irreg_pc = x.irreg; ma_pc = x.pc;
    ma_dmem_req = x.req; dmem_ack = x.ack; ex_rd_wen = x.wen; ex_rd_is_load = x.ld; ex_rd_addr = x.rd;
    id_rs1_used = x.u1; id_rs2_used = x.u2; id_rs1_addr = x.r1; id_rs2_addr = x.r2;
  endtask

  task automatic idle();
    vec_t x = '{default: '0};
    drive(x);
  endtask

  // One cycle: inputs already driven at the falling edge; check, then advance the model at the rising edge
  task automatic tick();
    logic [31:0] act;
    logic mp, mw, luh;
    logic [6:0] e;
    #1;
    act = ma_branch_taken ? ma_irreg_pc : ma_pc + 32'd4;
    mp  = ma_valid & ma_is_branch & (act != ma_predicted_next_pc);
    mw  = ma_valid & ma_dmem_req & ~dmem_ack;
    luh = ex_rd_wen & ex_rd_is_load & (ex_rd_addr != 0) &
          ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) | (id_rs2_used & (id_rs2_addr == ex_rd_addr)));
    if (!m_flush) assert (!(mp && ma_dmem_req));
    if (m_flush) e = 7'b0000100;
    else if (m_wait) e = !dmem_ack ? 7'b1111001 : (luh ? 7'b1100010 : 7'b0);
    else if (mw) e = 7'b1111001;
    else if (mp) e = 7'b0000110;
    else e = luh ? 7'b1100010 : 7'b0;
    last_ctrl = ctrl();
    chk("ctrl", last_ctrl, e);
    chk("redirect_valid", redirect_valid, m_flush);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("count", mispredict_count, m_cnt);
    @(posedge clk);
    if (m_flush) m_flush = 0;
    else if (m_wait) m_wait = !dmem_ack;
    else if (mw) m_wait = 1;
    else if (mp) begin
      m_flush = 1;
      m_rpc = act;
      if (m_cnt < 15) m_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = br(32'h100, 32'h104, 32'h180, 0, 0, 0, 7'b0000000, 0, 32'h0);
    tbl[1] = br(32'h200, 32'h204, 32'h300, 1, 0, 0, 7'b0000110, 1, 32'h300);
    tbl[2] = br(32'h380, 32'h480, 32'h400, 1, 1, 1, 7'b0000110, 1, 32'h400);
    tbl[3] = br(32'hFFFFFFFC, 32'h1000, 32'h1000, 0, 1, 1, 7'b0000110, 1, 32'h0);
    tbl[4] = lu(1, 1, 5'd5, 0, 1, 5'd0, 5'd5, 7'b1100010);
    tbl[5] = lu(1, 1, 5'd0, 1, 1, 5'd0, 5'd0, 7'b0000000);
    tbl[6] = lu(1, 1, 5'd7, 0, 0, 5'd7, 5'd7, 7'b0000000);
    tbl[7] = lu(1, 0, 5'd9, 1, 0, 5'd9, 5'd0, 7'b0000000);
    tbl[8] = br(32'h200, 32'h204, 32'h300, 1, 0, 0, 7'b0000000, 0, 32'h0);
    tbl[8].v = 0;
    tbl[9] = br(32'h500, 32'h600, 32'h600, 1, 1, 1, 7'b0000000, 0, 32'h0);
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", ctrl(), 7'b0);
    chk("reset_rv", redirect_valid, 0);
    chk("reset_rpc", redirect_pc, 0);
    chk("reset_cnt", mispredict_count, 0);
    @(negedge clk);
    rst = 1;
    tick();
    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      chk("tbl_ctrl", last_ctrl, tbl[i].exp_ctrl);
      chk("tbl_rv", redirect_valid, tbl[i].exp_rv);
      chk("tbl_rpc", redirect_pc, tbl[i].exp_rpc);
      idle();
      if (tbl[i].exp_rv) begin
        tick();
        chk("flush_cycle", last_ctrl, 7'b0000100);
        chk("rv_drop", redirect_valid, 0);
      end
    end
    chk("tbl_count", mispredict_count, 3);
    idle();
    ma_valid = 1; ma_dmem_req = 1; dmem_ack = 0;
    repeat (3) begin
      tick();
      chk("memwait_stall", last_ctrl, 7'b1111001);
    end
    dmem_ack = 1; ex_rd_wen = 1; ex_rd_is_load = 1; ex_rd_addr = 5; id_rs1_used = 1; id_rs1_addr = 5;
    tick();
    chk("ack_release", last_ctrl, 7'b1100010);
    idle();
    tick();
    ma_valid = 1; ma_dmem_req = 1; dmem_ack = 0;
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_mid_wait_ctrl", ctrl(), 7'b0);
    chk("rst_mid_wait_cnt", mispredict_count, 0);
    m_wait = 0; m_flush = 0; m_rpc = 0; m_cnt = 0;
    idle();
    #1 rst = 1;
    @(negedge clk);
    tick();
    chk("run_after_rst", last_ctrl, 7'b0);
    repeat (18) begin
      drive(tbl[1]);
      tick();
      idle();
      tick();
    end
    chk("saturate", mispredict_count, 4'hF);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pcs[3];
      logic [1:0] k;
      pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'hFFFFFFFC;
      ma_pc = pcs[$urandom_range(0, 2)];
      ma_irreg_pc = {$urandom_range(0, 3), 8'h40};
      k = 2'($urandom_range(0, 2));
      ma_predicted_next_pc = k == 0 ? ma_pc + 32'd4 : (k == 1 ? ma_irreg_pc : 32'h700);
      ma_valid = ($urandom % 4) != 0;
      ma_branch_taken = $urandom % 2;
      ma_taken_predicted = $urandom % 2;
      ma_next_pc_predicted = $urandom % 2;
      ma_dmem_req = ($urandom % 5) == 0;
      ma_is_branch = ma_dmem_req ? 1'b0 : 1'($urandom % 2);
      dmem_ack = $urandom % 2;
      ex_rd_wen = $urandom % 2;
      ex_rd_is_load = $urandom % 2;
      ex_rd_addr = 5'($urandom_range(0, 3));
      id_rs1_used = $urandom % 2;
      id_rs2_used = $urandom % 2;
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
